// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the LCD command queue.
//   lcd_q_state_t   - drain FSM states
//   LCD_INSTR_W     - LiquidCrystal instruction word width
//   LCD_AD          - IOBUS address of the push port
//   LCD_STATUS_AD   - IOBUS address of the status read port
//   lcd_status_word - packs queue status into the IOBUS read word
package lcd_pkg;

    localparam int LCD_INSTR_W = 10;

    localparam logic [31:0] LCD_AD        = 32'h11000160;
    localparam logic [31:0] LCD_STATUS_AD = 32'h11000140;

    // Status read word layout
    localparam int ST_BUSY_BIT  = 0;
    localparam int ST_EMPTY_BIT = 1;
    localparam int ST_FULL_BIT  = 2;
    localparam int ST_OVF_BIT   = 3;
    localparam int ST_COUNT_LSB = 8;
    localparam int ST_COUNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } lcd_q_state_t;

    function automatic logic [31:0] lcd_status_word(
        input logic       busy,
        input logic       empty,
        input logic       full,
        input logic       ovf,
        input logic [7:0] count
    );
        logic [31:0] w;
        w                                = '0;
        w[ST_BUSY_BIT]                   = busy;
        w[ST_EMPTY_BIT]                  = empty;
        w[ST_FULL_BIT]                   = full;
        w[ST_OVF_BIT]                    = ovf;
        w[ST_COUNT_LSB +: ST_COUNT_W]    = count;
        return w;
    endfunction

endpackage

// File: rtl/lcd_sync_fifo.sv
// lcd_sync_fifo: single-clock FIFO holding LCD instruction words.
//   CLK, RST  - clock, synchronous active-high reset
//   push      - write request; accepted when not full, or when a pop
//               happens in the same cycle
//   pop       - read request; ignored when empty
//   wr_data   - word to store
//   rd_data   - head word (combinational read of the read pointer)
//   count     - occupancy, 0..DEPTH
//   full/empty- derived from count
module lcd_sync_fifo
    import lcd_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = LCD_INSTR_W
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    // A pop frees the slot this edge, so a push into a full FIFO still fits.
    assign do_push = push && (!full || do_pop);

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // DEPTH is a power of two, so pointer wrap is plain overflow.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/lcd_cmd_queue.sv
// lcd_cmd_queue: buffers CPU-written LCD instruction words and hands them
// to the LiquidCrystal driver one at a time, pacing on its ready line.
//   CLK, RST   - clock, synchronous active-high reset
//   WR_EN      - one-cycle push strobe from the IOBUS decode
//   WR_DATA    - instruction word to queue
//   CLR_OVF    - one-cycle clear of the sticky overflow flag
//   LCD_READY  - driver idle/ready
//   LCD_INSTR  - word presented to the driver, held until the next issue
//   LCD_STB    - one-cycle "new word valid" pulse
//   Q_COUNT    - queue occupancy
//   Q_EMPTY    - queue empty
//   Q_FULL     - queue full
//   Q_OVF      - sticky: a push was dropped because the queue was full
//   BUSY       - queue non-empty or a word still in flight
module lcd_cmd_queue
    import lcd_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int WIDTH       = LCD_INSTR_W,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     WR_EN,
    input  logic [WIDTH-1:0]         WR_DATA,
    input  logic                     CLR_OVF,
    input  logic                     LCD_READY,
    output logic [WIDTH-1:0]         LCD_INSTR,
    output logic                     LCD_STB,
    output logic [$clog2(DEPTH):0]   Q_COUNT,
    output logic                     Q_EMPTY,
    output logic                     Q_FULL,
    output logic                     Q_OVF,
    output logic                     BUSY
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    lcd_q_state_t     state;
    lcd_q_state_t     state_nx;
    logic [TW-1:0]    tmo_cnt;
    logic [WIDTH-1:0] head;
    logic             pop;
    logic             drop;
    logic             tmo_hit;

    lcd_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .push    (WR_EN),
        .pop     (pop),
        .wr_data (WR_DATA),
        .rd_data (head),
        .count   (Q_COUNT),
        .full    (Q_FULL),
        .empty   (Q_EMPTY)
    );

    // tmo_cnt counts completed WAIT_BUSY cycles; the hit fires on the last one.
    assign tmo_hit = (tmo_cnt == TW'(ACK_TIMEOUT - 1));
    assign drop    = WR_EN && Q_FULL && !pop;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (!Q_EMPTY && LCD_READY) state_nx = ISSUE;
            ISSUE:     state_nx = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!LCD_READY)   state_nx = WAIT_DONE;
                else if (tmo_hit) state_nx = IDLE;   // driver never acked; assume taken
            end
            WAIT_DONE: if (LCD_READY) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        LCD_STB = 1'b0;
        pop     = 1'b0;
        if (state == ISSUE) begin
            LCD_STB = 1'b1;
            pop     = 1'b1;
        end
        BUSY = !Q_EMPTY || (state != IDLE);
    end

    // The word is latched on entry to ISSUE so it is already stable on
    // LCD_INSTR for the whole strobe cycle; the pop happens at the end of it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            LCD_INSTR <= '0;
            tmo_cnt   <= '0;
            Q_OVF     <= 1'b0;
        end else begin
            if (state == IDLE && state_nx == ISSUE) LCD_INSTR <= head;

            if (state == ISSUE)          tmo_cnt <= '0;
            else if (state == WAIT_BUSY) tmo_cnt <= tmo_cnt + TW'(1);

            // A drop in the same cycle as a clear must leave the flag set.
            if (drop)         Q_OVF <= 1'b1;
            else if (CLR_OVF) Q_OVF <= 1'b0;
        end
    end

endmodule
